// File: rtl/key_cmd_queue.sv
// Key command queue: turns dealer control-key make events into 4-bit command
// codes, drops typematic repeats, and buffers the codes in a small FIFO.
module key_cmd_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic [8:0]    last_change,
    input  logic [511:0]  key_down,
    input  logic          flush,
    input  logic          cmd_ready,
    output logic          cmd_valid,
    output logic [3:0]    cmd_code,
    output logic [AW:0]   count,
    output logic          overflow
);

    // Handshake: an entry moves to the consumer on every rising edge where
    // cmd_valid and cmd_ready are both high; cmd_code is stable while
    // cmd_valid=1 and cmd_ready=0, and cmd_valid never drops without a pop.
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [15:0]   armed;

    logic          mapped;
    logic [3:0]    code;
    logic          event_hit;
    logic          is_make;
    logic          push_req;
    logic          push_acc;
    logic          pop;
    logic          full;
    logic          empty_after_pop;

    always_comb begin
        mapped = 1'b1;
        code   = 4'd0;
        unique case (last_change)
            9'h045: code = 4'd0;
            9'h016: code = 4'd1;
            9'h01E: code = 4'd2;
            9'h026: code = 4'd3;
            9'h025: code = 4'd4;
            9'h02E: code = 4'd5;
            9'h036: code = 4'd6;
            9'h03D: code = 4'd7;
            9'h03E: code = 4'd8;
            9'h046: code = 4'd9;
            9'h05A: code = 4'd10;
            9'h066: code = 4'd11;
            9'h029: code = 4'd12;
            9'h076: code = 4'd13;
            9'h16B: code = 4'd14;
            9'h174: code = 4'd15;
            default: mapped = 1'b0;
        endcase
    end

    assign cmd_valid       = (count != '0);
    assign pop             = cmd_valid & cmd_ready;
    assign full            = (count == FULL_COUNT);
    assign rd_next         = rd_ptr + AW'(1);
    assign event_hit       = key_valid & mapped;
    assign is_make         = key_down[last_change];
    assign push_req        = event_hit & is_make & ~armed[code];
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_acc        = push_req & (~full | pop);
    // The pushed code becomes the head when nothing older survives this edge.
    assign empty_after_pop = (count == '0) | ((count == ONE_COUNT) & pop);

    always_ff @(posedge clk) begin
        if (push_acc && !flush) begin
            mem[wr_ptr] <= code;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            armed    <= '0;
            overflow <= 1'b0;
            cmd_code <= 4'd0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            armed    <= '0;
            overflow <= 1'b0;
        end else begin
            if (event_hit) begin
                armed[code] <= is_make;
            end
            if (push_req && !push_acc) begin
                overflow <= 1'b1;
            end
            if (push_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            if (push_acc && !pop) begin
                count <= count + ONE_COUNT;
            end else if (pop && !push_acc) begin
                count <= count - ONE_COUNT;
            end
            if (push_acc && empty_after_pop) begin
                cmd_code <= code;
            end else if (pop) begin
                cmd_code <= mem[rd_next];
            end
        end
    end

endmodule

// File: tb/tb_key_cmd_queue.sv
// Self-checking bench for key_cmd_queue: scenario tasks with a scoreboard
// queue of expected command codes compared as entries leave the FIFO.
module tb_key_cmd_queue;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic         flush;
  logic         cmd_ready;
  logic         cmd_valid;
  logic [3:0]   cmd_code;
  logic [3:0]   count;
  logic         overflow;

  logic [511:0] kd;
  logic [3:0]   exp_q[$];
  int           tests_run;
  int           fails;

  key_cmd_queue #(.DEPTH(8), .AW(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .last_change (last_change),
    .key_down    (key_down),
    .flush       (flush),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .count       (count),
    .overflow    (overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one key event; optionally records the code the FIFO must emit
  task automatic key_event(input logic [8:0] lc, input logic down,
                           input logic exp_push, input logic [3:0] exp_code);
    kd[lc]      = down;
    key_down    = kd;
    last_change = lc;
    key_valid   = 1'b1;
    if (exp_push) exp_q.push_back(exp_code);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
  endtask

  // scoreboard: pop the FIFO until empty, comparing each head with exp_q
  task automatic drain(input string name);
    int guard;
    logic [3:0] e;
    guard = 0;
    while (cmd_valid && guard < 40) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL %s_extra: got code %0d, expected no entry", name, cmd_code);
      end else begin
        e = exp_q.pop_front();
        if (cmd_code !== e) begin
          fails++;
          $display("FAIL %s_code: got %0d, expected %0d", name, cmd_code, e);
        end
      end
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      guard++;
    end
    tests_run++;
    if (exp_q.size() != 0 || cmd_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s_drain: %0d expected entries left, cmd_valid=%b", name, exp_q.size(), cmd_valid);
    end
    exp_q.delete();
  endtask

  task automatic check_count(input string name, input logic [3:0] exp_cnt);
    tests_run++;
    if (count !== exp_cnt) begin
      fails++;
      $display("FAIL %s_count: got %0d, expected %0d", name, count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    tests_run++;
    if ({cmd_valid, cmd_code, count, overflow} !== 10'b0) begin
      fails++;
      $display("FAIL reset: got valid=%b code=%0d count=%0d ovf=%b, expected all 0",
               cmd_valid, cmd_code, count, overflow);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    key_event(9'h026, 1'b1, 1'b1, 4'd3);
    tests_run++;
    if (cmd_valid !== 1'b1 || cmd_code !== 4'd3) begin
      fails++;
      $display("FAIL single_head: got valid=%b code=%0d, expected valid=1 code=3", cmd_valid, cmd_code);
    end
    check_count("single", 4'd1);
    drain("single");
    check_count("single_after", 4'd0);
    key_event(9'h026, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_repeat();
    key_event(9'h05A, 1'b1, 1'b1, 4'd10);
    key_event(9'h05A, 1'b1, 1'b0, 4'd0);
    key_event(9'h05A, 1'b1, 1'b0, 4'd0);
    key_event(9'h05A, 1'b0, 1'b0, 4'd0);
    key_event(9'h05A, 1'b1, 1'b1, 4'd10);
    check_count("repeat", 4'd2);
    drain("repeat");
    key_event(9'h05A, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_unmapped();
    key_event(9'h01C, 1'b1, 1'b0, 4'd0);
    key_event(9'h06B, 1'b1, 1'b0, 4'd0);
    check_count("unmapped", 4'd0);
    key_event(9'h16B, 1'b1, 1'b1, 4'd14);
    check_count("extend", 4'd1);
    drain("unmapped");
    key_event(9'h16B, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_overflow();
    logic [8:0] keys [9];
    keys = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D, 9'h03E};
    for (int i = 0; i < 9; i++) key_event(keys[i], 1'b1, (i < 8), 4'(i));
    check_count("overflow", 4'd8);
    tests_run++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_flag: got %b, expected 1", overflow);
    end
    drain("overflow");
    tests_run++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_sticky: got %b, expected 1", overflow);
    end
    for (int i = 0; i < 9; i++) key_event(keys[i], 1'b0, 1'b0, 4'd0);
    do_flush();
  endtask

  task automatic test_full_push_pop();
    logic [8:0] keys [8];
    logic [3:0] e;
    keys = '{9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D};
    // start from a non-zero pointer so the run crosses the wrap point
    key_event(9'h03E, 1'b1, 1'b1, 4'd8);
    key_event(9'h046, 1'b1, 1'b1, 4'd9);
    drain("prewrap");
    for (int i = 0; i < 8; i++) key_event(keys[i], 1'b1, 1'b1, 4'(i));
    check_count("full", 4'd8);
    e = exp_q.pop_front();
    tests_run++;
    if (cmd_code !== e) begin
      fails++;
      $display("FAIL fullpp_head: got %0d, expected %0d", cmd_code, e);
    end
    cmd_ready = 1'b1;
    key_event(9'h174, 1'b1, 1'b1, 4'd15);
    cmd_ready = 1'b0;
    check_count("fullpp", 4'd8);
    tests_run++;
    if (overflow !== 1'b0 || cmd_code !== 4'd1) begin
      fails++;
      $display("FAIL fullpp_state: got ovf=%b code=%0d, expected ovf=0 code=1", overflow, cmd_code);
    end
    drain("fullpp");
    for (int i = 0; i < 8; i++) key_event(keys[i], 1'b0, 1'b0, 4'd0);
    key_event(9'h03E, 1'b0, 1'b0, 4'd0);
    key_event(9'h046, 1'b0, 1'b0, 4'd0);
    key_event(9'h174, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_flush();
    key_event(9'h045, 1'b1, 1'b0, 4'd0);
    key_event(9'h016, 1'b1, 1'b0, 4'd0);
    key_event(9'h01E, 1'b1, 1'b0, 4'd0);
    key_event(9'h026, 1'b1, 1'b0, 4'd0);
    check_count("preflush", 4'd4);
    flush = 1'b1;
    key_event(9'h025, 1'b1, 1'b0, 4'd0);
    flush = 1'b0;
    tests_run++;
    if (count !== 4'd0 || cmd_valid !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL flush_state: got count=%0d valid=%b ovf=%b, expected 0 0 0", count, cmd_valid, overflow);
    end
    key_event(9'h045, 1'b1, 1'b1, 4'd0);
    key_event(9'h025, 1'b1, 1'b1, 4'd4);
    check_count("postflush", 4'd2);
    drain("flush");
    key_event(9'h016, 1'b0, 1'b0, 4'd0);
    key_event(9'h01E, 1'b0, 1'b0, 4'd0);
    key_event(9'h026, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic test_async_reset();
    logic [8:0] keys [9];
    keys = '{9'h066, 9'h029, 9'h076, 9'h03E, 9'h046, 9'h036, 9'h03D, 9'h02E, 9'h05A};
    for (int i = 0; i < 9; i++) key_event(keys[i], 1'b1, 1'b0, 4'd0);
    tests_run++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL prereset_ovf: got %b, expected 1", overflow);
    end
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (count !== 4'd0 || cmd_valid !== 1'b0 || overflow !== 1'b0 || cmd_code !== 4'd0) begin
      fails++;
      $display("FAIL async_reset: got count=%0d valid=%b ovf=%b code=%0d, expected 0 0 0 0",
               count, cmd_valid, overflow, cmd_code);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    key_event(9'h066, 1'b1, 1'b1, 4'd11);
    key_event(9'h076, 1'b1, 1'b1, 4'd13);
    check_count("postreset", 4'd2);
    drain("async");
  endtask

  initial begin
    tests_run   = 0;
    fails       = 0;
    kd          = '0;
    key_down    = '0;
    key_valid   = 1'b0;
    last_change = 9'd0;
    flush       = 1'b0;
    cmd_ready   = 1'b0;
    rst         = 1'b1;
    #3;
    test_reset();
    test_single();
    test_repeat();
    test_unmapped();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/key_cmd_queue.md
Name: key_cmd_queue

Overview:
- Sits directly downstream of the PS/2 keyboard decoder and consumes its key_valid / last_change / key_down outputs.
- Translates make events of the dealer's control keys into 4-bit command codes, suppresses typematic auto-repeat, and buffers commands in a small FIFO.
- The dealer game FSM pops commands through a valid/ready handshake, so no keystroke is lost while the game FSM is busy.

Parameters:
- DEPTH, 8, FIFO depth in entries; power of two, 2..16.
- AW, 3, pointer width; equals log2(DEPTH).

Ports:
- clk, input, 1, system clock; all state changes on its rising edge.
- rst, input, 1, asynchronous active-low reset.
- key_valid, input, 1, one-cycle event pulse from the keyboard decoder.
- last_change, input, 9, {extend, scancode} of the event.
- key_down, input, 512, key-state vector; bit [last_change] is already updated in the cycle key_valid is high.
- flush, input, 1, synchronous clear of FIFO contents and arm flags.
- cmd_ready, input, 1, consumer accepts the head entry.
- cmd_valid, output, 1, FIFO non-empty.
- cmd_code, output, 4, head command code.
- count, output, AW+1, current occupancy.
- overflow, output, 1, sticky flag: a command was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - cmd_valid=0, cmd_code=0, count=0, overflow=0.
  - Pointers=0, armed[15:0]=0.
- Key map (last_change -> code):
  - 0x045->0, 0x016->1, 0x01E->2, 0x026->3, 0x025->4, 0x02E->5, 0x036->6, 0x03D->7, 0x03E->8, 0x046->9.
  - 0x05A->10 (enter), 0x066->11 (backspace), 0x029->12 (space), 0x076->13 (esc), 0x16B->14 (left), 0x174->15 (right).
  - Any other code is ignored: no push, no flag change.
- Event classification, only in cycles where key_valid=1 and the code is mapped:
  - Make: key_down[last_change]=1.
    - If armed[code]=0: set armed[code] and request a push.
    - If armed[code]=1: the event is a typematic repeat and is dropped silently.
  - Break: key_down[last_change]=0. Clear armed[code]; no push.
- Push/pop rules:
  - pop = cmd_valid & cmd_ready.
  - A push is accepted when count<DEPTH, or when count==DEPTH and pop is high in the same cycle (simultaneous push+pop on full is legal; count unchanged).
  - A push rejected on full sets overflow=1. armed[code] is still set, so the repeat does not retry.
  - Simultaneous push and pop on empty: the pop is not possible (cmd_valid=0); the push lands normally.
  - overflow is cleared only by reset or flush.
- Latency and head register:
  - A push at edge N makes cmd_valid=1 and cmd_code valid after edge N (visible in cycle N+1) when the FIFO was empty.
  - cmd_code is a registered read of the head: it equals mem[rd_ptr] and updates the edge after a pop. It holds when cmd_ready=0.
  - cmd_code is don't-care when cmd_valid=0; RTL drives the stale head.
- Pointer arithmetic:
  - Pointers are AW bits, wrapping modulo DEPTH.
  - count is a separate AW+1 counter: +1 on push only, -1 on pop only, unchanged on both or neither.
- Flush: takes priority over push and pop in the same cycle.
  - Pointers=0, count=0, armed=0, overflow=0, cmd_valid=0.
  - The key event in that cycle is discarded.
- Reset mid-operation: all state returns to reset values immediately; no partial entry is kept.

Test Plan:
- Empty FIFO, key_valid with last_change=0x026, key_down[0x026]=1 -> cmd_valid=1, cmd_code=3 the next cycle, count=1; cmd_ready=1 for one cycle -> cmd_valid=0, count=0.
- Make 0x05A three times (repeats) then break, then make again, with cmd_ready=0 -> exactly two entries of code 10, count=2.
- Unmapped 0x01C make, and 0x06B without extend versus 0x16B -> only 0x16B pushes code 14.
- Nine distinct mapped makes with cmd_ready=0, DEPTH=8 -> count=8, overflow=1; popping yields codes in push order, and the ninth is absent.
- FIFO full and cmd_ready=1 in the same cycle as a new make of 0x174 -> count stays 8, overflow=0, code 15 is at the tail; then drain 8 entries to exercise pointer wrap.
- After four pushes: assert flush together with a make; separately, drive rst low asynchronously mid-stream -> count=0, cmd_valid=0, overflow=0, the make is dropped, and the next make of the same key pushes (armed cleared).
